mure_retire_arbiter: RTL and testbench

- Shares the single write port of the trace-encoder uop FIFO between the NRET=2 CPU commit ports.
- Captures 0, 1 or 2 retired instructions per cycle into a small in-order holding buffer. Drains one fifo_entry_s per cycle into the uop FIFO under valid/ready.
- The CPU cannot be stalled, so on lack of space the block drops instructions, flags overflow, and re-synchronises once drained.
- Sits between the CVA6 commit stage (with itype detection) and the uop FIFO.

---
 rtl/mure_retire_arbiter.sv | 244 ++++++++++++++++++++++++
 tb/tb_mure_retire_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mure_retire_arbiter.sv
// Retire arbiter: merges the NRET commit ports into one in-order uop-FIFO write stream
// through a small holding buffer; drops and re-synchronises on overflow. Optional: MURE_DROP_CNT_EN.
package mure_pkg;
  localparam int unsigned NRET      = 2;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned INST_LEN  = 32;
  localparam int unsigned ITYPE_LEN = 3;
  localparam int unsigned CAUSE_LEN = 5;
  localparam int unsigned PRIV_LEN  = 2;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      pc;
    logic [INST_LEN-1:0]  inst;
    logic [ITYPE_LEN-1:0] itype;
    logic                 compressed;
    logic                 exception;
    logic                 interrupt;
    logic                 eret;
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
  } fifo_entry_s;
endpackage

module mure_retire_arbiter
  import mure_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NRET-1:0]           valid_i,
  input  logic [NRET*XLEN-1:0]      pc_i,
  input  logic [NRET*INST_LEN-1:0]  inst_i,
  input  logic [NRET*ITYPE_LEN-1:0] itype_i,
  input  logic [NRET-1:0]           compressed_i,
  input  logic [NRET-1:0]           exception_i,
  input  logic [NRET-1:0]           interrupt_i,
  input  logic [NRET-1:0]           eret_i,
  input  logic [CAUSE_LEN-1:0]      cause_i,
  input  logic [XLEN-1:0]           tval_i,
  input  logic [PRIV_LEN-1:0]       priv_i,
  output fifo_entry_s               entry_o,
  output logic                      entry_valid_o,
  input  logic                      fifo_ready_i,
  output logic                      overflow_o,
  output logic                      resync_o,
  output logic [$clog2(DEPTH):0]    occupancy_o,
  output logic                      idle_o
`ifdef MURE_DROP_CNT_EN
  ,
  output logic [15:0]               dropped_cnt_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_DROP   = 2'd1,
    ST_RESYNC = 2'd2
  } state_e;

  state_e            state_q, state_d;
  fifo_entry_s       mem_q [DEPTH];
  fifo_entry_s       mem_d [DEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d, wr1_s;
  logic [CW-1:0]     cnt_q, cnt_d;
  fifo_entry_s       entry_q, entry_d;
  logic              ev_q, ev_d;
  logic              ovf_q, ovf_d;
  logic              rsy_q, rsy_d;
  logic              idle_q, idle_d;

  fifo_entry_s       port_s [NRET];
  fifo_entry_s       first_s;
  logic              cap0_s, cap1_s;
  logic [1:0]        cap_n_s;
  logic [CW:0]       need_s;
  logic              fits_s;
  logic              pop_s;
  logic              wr_en_s;
  logic              ovf_drop_s;

  // Per-port candidate entries; shared trap fields go into every entry.
  always_comb begin
    for (int i = 0; i < NRET; i++) begin
      port_s[i].valid      = 1'b1;
      port_s[i].pc         = pc_i[i*XLEN +: XLEN];
      port_s[i].inst       = inst_i[i*INST_LEN +: INST_LEN];
      port_s[i].itype      = itype_i[i*ITYPE_LEN +: ITYPE_LEN];
      port_s[i].compressed = compressed_i[i];
      port_s[i].exception  = exception_i[i];
      port_s[i].interrupt  = interrupt_i[i];
      port_s[i].eret       = eret_i[i];
      port_s[i].cause      = cause_i;
      port_s[i].tval       = tval_i;
      port_s[i].priv       = priv_i;
    end
  end

  // Capture set: port 1 is shadowed by a trapping port 0.
  always_comb begin
    cap0_s  = valid_i[0];
    cap1_s  = valid_i[1] & ~(valid_i[0] & (exception_i[0] | interrupt_i[0]));
    cap_n_s = {1'b0, cap0_s} + {1'b0, cap1_s};
    first_s = cap0_s ? port_s[0] : port_s[1];
    need_s  = {1'b0, cnt_q} + (CW+1)'(cap_n_s);
    fits_s  = (need_s <= (CW+1)'(DEPTH));
  end

  assign pop_s = ev_q & fifo_ready_i;
  assign wr1_s = wr_q + PW'(1'b1);

  // Overflow FSM: space is judged against occupancy before this cycle's pop.
  always_comb begin
    state_d    = state_q;
    ovf_d      = ovf_q;
    rsy_d      = 1'b0;
    wr_en_s    = 1'b0;
    ovf_drop_s = 1'b0;
    case (state_q)
      ST_NORMAL, ST_RESYNC: begin
        if (cap_n_s == 2'd0) begin
          state_d = state_q;
        end else if (fits_s) begin
          wr_en_s = 1'b1;
          state_d = ST_NORMAL;
          if (state_q == ST_RESYNC) begin
            rsy_d = 1'b1;
            ovf_d = 1'b0;
          end else begin
            rsy_d = 1'b0;
          end
        end else begin
          ovf_drop_s = 1'b1;
          ovf_d      = 1'b1;
          state_d    = ST_DROP;
        end
      end
      ST_DROP: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_RESYNC;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_NORMAL;
      end
    endcase
  end

  // Buffer write/pop and the next registered head.
  always_comb begin
    mem_d = mem_q;
    if (wr_en_s) begin
      mem_d[wr_q] = first_s;
      if (cap_n_s == 2'd2) begin
        mem_d[wr1_s] = port_s[1];
      end else begin
        mem_d[wr1_s] = mem_q[wr1_s];
      end
      wr_d  = wr_q + PW'(cap_n_s);
      cnt_d = cnt_q + CW'(cap_n_s) - CW'(pop_s);
    end else begin
      wr_d  = wr_q;
      cnt_d = cnt_q - CW'(pop_s);
    end
    rd_d    = rd_q + PW'(pop_s);
    ev_d    = (cnt_d != {CW{1'b0}});
    entry_d = ev_d ? mem_d[rd_d] : '0;
    idle_d  = ~ev_d & (state_d == ST_NORMAL);
  end

  // State and buffer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_NORMAL;
      wr_q    <= {PW{1'b0}};
      rd_q    <= {PW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      entry_q <= '0;
      ev_q    <= 1'b0;
      ovf_q   <= 1'b0;
      rsy_q   <= 1'b0;
      idle_q  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
      ev_q    <= ev_d;
      ovf_q   <= ovf_d;
      rsy_q   <= rsy_d;
      idle_q  <= idle_d;
      mem_q   <= mem_d;
    end
  end

  assign entry_o       = entry_q;
  assign entry_valid_o = ev_q;
  assign overflow_o    = ovf_q;
  assign resync_o      = rsy_q;
  assign occupancy_o   = cnt_q;
  assign idle_o        = idle_q;

`ifdef MURE_DROP_CNT_EN
  logic [15:0] dcnt_q, dcnt_d;
  logic [1:0]  drop_n_s;
  logic [16:0] dsum_s;

  // Saturating drop counter; the resync pulse value is held, then cleared.
  always_comb begin
    drop_n_s = (ovf_drop_s | (state_q == ST_DROP)) ? cap_n_s : 2'd0;
    dsum_s   = {1'b0, dcnt_q} + {15'd0, drop_n_s};
    if (rsy_q) begin
      dcnt_d = 16'd0;
    end else if (dsum_s[16]) begin
      dcnt_d = 16'hFFFF;
    end else begin
      dcnt_d = dsum_s[15:0];
    end
  end

  // Drop counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dcnt_q <= 16'd0;
    end else begin
      dcnt_q <= dcnt_d;
    end
  end

  assign dropped_cnt_o = dcnt_q;
`endif

endmodule

// File: tb/tb_mure_retire_arbiter.sv
// Bench for mure_retire_arbiter: directed vector table, hand sequences, then random
// stimulus against a queue-based reference model.
module tb_mure_retire_arbiter;
  import mure_pkg::*;

  localparam int DEPTH = 4;

  logic                      clk = 1'b0;
  logic                      rst_i;
  logic [NRET-1:0]           valid_i;
  logic [NRET*XLEN-1:0]      pc_i;
  logic [NRET*INST_LEN-1:0]  inst_i;
  logic [NRET*ITYPE_LEN-1:0] itype_i;
  logic [NRET-1:0]           compressed_i, exception_i, interrupt_i, eret_i;
  logic [CAUSE_LEN-1:0]      cause_i;
  logic [XLEN-1:0]           tval_i;
  logic [PRIV_LEN-1:0]       priv_i;
  fifo_entry_s               entry_o;
  logic                      entry_valid_o, fifo_ready_i, overflow_o, resync_o, idle_o;
  logic [$clog2(DEPTH):0]    occupancy_o;
`ifdef MURE_DROP_CNT_EN
  logic [15:0]               dropped_cnt;
`endif

  always #5 clk = ~clk;

  mure_retire_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i), .inst_i(inst_i),
    .itype_i(itype_i), .compressed_i(compressed_i), .exception_i(exception_i),
    .interrupt_i(interrupt_i), .eret_i(eret_i), .cause_i(cause_i), .tval_i(tval_i),
    .priv_i(priv_i), .entry_o(entry_o), .entry_valid_o(entry_valid_o),
    .fifo_ready_i(fifo_ready_i), .overflow_o(overflow_o), .resync_o(resync_o),
    .occupancy_o(occupancy_o), .idle_o(idle_o)
`ifdef MURE_DROP_CNT_EN
    , .dropped_cnt_o(dropped_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic [1:0] v, input logic [1:0] exc,
                       input logic [1:0] intr, input logic [1:0] er, input logic rdy,
                       input logic [31:0] pc0, input logic [31:0] pc1, input logic [4:0] cause);
    rst_i        = r;
    valid_i      = v;
    exception_i  = exc;
    interrupt_i  = intr;
    eret_i       = er;
    fifo_ready_i = rdy;
    pc_i         = {pc1, pc0};
    inst_i       = {~pc1, ~pc0};
    itype_i      = {pc1[4:2], pc0[4:2]};
    compressed_i = {pc1[1], pc0[1]};
    cause_i      = cause;
    tval_i       = pc0 ^ 32'h0000_1234;
    priv_i       = pc1[6:5];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  fifo_entry_s mq[$];
  bit m_ovf, m_rsy, m_drop, m_wait;
  int m_dcnt;

  function automatic fifo_entry_s mk(input int i);
    fifo_entry_s e;
    e.valid      = 1'b1;
    e.pc         = pc_i[i*32 +: 32];
    e.inst       = inst_i[i*32 +: 32];
    e.itype      = itype_i[i*3 +: 3];
    e.compressed = compressed_i[i];
    e.exception  = exception_i[i];
    e.interrupt  = interrupt_i[i];
    e.eret       = eret_i[i];
    e.cause      = cause_i;
    e.tval       = tval_i;
    e.priv       = priv_i;
    return e;
  endfunction

  task automatic model_step();
    fifo_entry_s cap[$];
    int free, n, dropped;
    bit rsy_now;
    if (rst_i) begin
      mq.delete();
      m_ovf = 0; m_rsy = 0; m_drop = 0; m_wait = 0; m_dcnt = 0;
      return;
    end
    rsy_now = m_rsy;
    m_rsy   = 0;
    if (valid_i[0]) cap.push_back(mk(0));
    if (valid_i[1] && !(valid_i[0] && (exception_i[0] || interrupt_i[0]))) cap.push_back(mk(1));
    n       = cap.size();
    free    = DEPTH - mq.size();
    dropped = 0;
    if (m_drop) begin
      dropped = n;
      if (mq.size() == 0) begin m_drop = 0; m_wait = 1; end
    end
    if (mq.size() > 0 && fifo_ready_i) void'(mq.pop_front());
    if (!m_drop && !(dropped > 0) && n > 0) begin
      if (n <= free) begin
        foreach (cap[k]) mq.push_back(cap[k]);
        if (m_wait) begin m_rsy = 1; m_ovf = 0; m_wait = 0; end
      end else begin
        dropped = n; m_ovf = 1; m_drop = 1; m_wait = 0;
      end
    end
    if (rsy_now) m_dcnt = 0;
    else m_dcnt = (m_dcnt + dropped > 65535) ? 65535 : m_dcnt + dropped;
  endtask

  task automatic check_model(input int cyc);
    fifo_entry_s exp_e;
    bit ev;
    ev    = (mq.size() > 0);
    exp_e = ev ? mq[0] : '0;
    chk($sformatf("rnd%0d_valid", cyc), entry_valid_o, ev);
    chk($sformatf("rnd%0d_entry", cyc), entry_o, exp_e);
    chk($sformatf("rnd%0d_occ", cyc), occupancy_o, mq.size());
    chk($sformatf("rnd%0d_ovf", cyc), overflow_o, m_ovf);
    chk($sformatf("rnd%0d_resync", cyc), resync_o, m_rsy);
    chk($sformatf("rnd%0d_idle", cyc), idle_o, (mq.size() == 0) && !m_drop && !m_wait);
`ifdef MURE_DROP_CNT_EN
    chk($sformatf("rnd%0d_dcnt", cyc), dropped_cnt, m_dcnt);
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst; logic [1:0] v; logic [1:0] exc; logic rdy;
    logic [31:0] pc0, pc1; logic [4:0] cause;
    logic [2:0] occ; logic ev; logic [31:0] hpc; logic hexc; logic [4:0] hcause;
    logic ovf, rsy, idle; logic [15:0] dcnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mv(input logic r, input logic [1:0] v, input logic [1:0] exc,
      input logic rdy, input logic [31:0] pc0, input logic [31:0] pc1, input logic [4:0] cause,
      input logic [2:0] occ, input logic ev, input logic [31:0] hpc, input logic hexc,
      input logic [4:0] hcause, input logic ovf, input logic rsy, input logic idle,
      input logic [15:0] dcnt);
    vec_t t;
    t.rst = r; t.v = v; t.exc = exc; t.rdy = rdy; t.pc0 = pc0; t.pc1 = pc1; t.cause = cause;
    t.occ = occ; t.ev = ev; t.hpc = hpc; t.hexc = hexc; t.hcause = hcause;
    t.ovf = ovf; t.rsy = rsy; t.idle = idle; t.dcnt = dcnt;
    return t;
  endfunction

  initial begin
    int waited;
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);

    //           rst  v      exc    rdy  pc0          pc1          cs    occ  ev  hpc          he  hc    ovf rsy idl dcnt
    tbl.push_back(mv(1, 2'b00, 2'b00, 0, 32'h0,       32'h0,       5'd0, 3'd0, 0, 32'h0,       0, 5'd0, 0, 0, 1, 16'd0));
    tbl.push_back(mv(0, 2'b11, 2'b00, 1, 32'h100,     32'h104,     5'd0, 3'd2, 1, 32'h100,     0, 5'd0, 0, 0, 0, 16'd0));
    tbl.push_back(mv(0, 2'b00, 2'b00, 1, 32'h0,       32'h0,       5'd0, 3'd1, 1, 32'h104,     0, 5'd0, 0, 0, 0, 16'd0));
    tbl.push_back(mv(0, 2'b00, 2'b00, 1, 32'h0,       32'h0,       5'd0, 3'd0, 0, 32'h0,       0, 5'd0, 0, 0, 1, 16'd0));
    tbl.push_back(mv(0, 2'b11, 2'b01, 0, 32'h300,     32'h304,     5'd2, 3'd1, 1, 32'h300,     1, 5'd2, 0, 0, 0, 16'd0));
    tbl.push_back(mv(0, 2'b00, 2'b00, 1, 32'h0,       32'h0,       5'd0, 3'd0, 0, 32'h0,       0, 5'd0, 0, 0, 1, 16'd0));
    tbl.push_back(mv(0, 2'b01, 2'b00, 0, 32'h10,      32'h0,       5'd0, 3'd1, 1, 32'h10,      0, 5'd0, 0, 0, 0, 16'd0));
    tbl.push_back(mv(0, 2'b01, 2'b00, 0, 32'h14,      32'h0,       5'd0, 3'd2, 1, 32'h10,      0, 5'd0, 0, 0, 0, 16'd0));
    tbl.push_back(mv(0, 2'b01, 2'b00, 0, 32'h18,      32'h0,       5'd0, 3'd3, 1, 32'h10,      0, 5'd0, 0, 0, 0, 16'd0));
    tbl.push_back(mv(0, 2'b01, 2'b00, 0, 32'h1c,      32'h0,       5'd0, 3'd4, 1, 32'h10,      0, 5'd0, 0, 0, 0, 16'd0));
    tbl.push_back(mv(0, 2'b01, 2'b00, 0, 32'h20,      32'h0,       5'd0, 3'd4, 1, 32'h10,      0, 5'd0, 1, 0, 0, 16'd1));
    tbl.push_back(mv(0, 2'b01, 2'b00, 1, 32'h30,      32'h0,       5'd0, 3'd3, 1, 32'h14,      0, 5'd0, 1, 0, 0, 16'd2));
    tbl.push_back(mv(0, 2'b01, 2'b00, 1, 32'h34,      32'h0,       5'd0, 3'd2, 1, 32'h18,      0, 5'd0, 1, 0, 0, 16'd3));
    tbl.push_back(mv(0, 2'b01, 2'b00, 1, 32'h38,      32'h0,       5'd0, 3'd1, 1, 32'h1c,      0, 5'd0, 1, 0, 0, 16'd4));
    tbl.push_back(mv(0, 2'b01, 2'b00, 1, 32'h3c,      32'h0,       5'd0, 3'd0, 0, 32'h0,       0, 5'd0, 1, 0, 0, 16'd5));
    tbl.push_back(mv(0, 2'b01, 2'b00, 1, 32'h40,      32'h0,       5'd0, 3'd0, 0, 32'h0,       0, 5'd0, 1, 0, 0, 16'd6));
    tbl.push_back(mv(0, 2'b01, 2'b00, 1, 32'h200,     32'h0,       5'd0, 3'd1, 1, 32'h200,     0, 5'd0, 0, 1, 0, 16'd6));
    tbl.push_back(mv(0, 2'b00, 2'b00, 1, 32'h0,       32'h0,       5'd0, 3'd0, 0, 32'h0,       0, 5'd0, 0, 0, 1, 16'd0));
    tbl.push_back(mv(0, 2'b01, 2'b00, 0, 32'h40,      32'h0,       5'd0, 3'd1, 1, 32'h40,      0, 5'd0, 0, 0, 0, 16'd0));
    tbl.push_back(mv(0, 2'b01, 2'b00, 0, 32'h44,      32'h0,       5'd0, 3'd2, 1, 32'h40,      0, 5'd0, 0, 0, 0, 16'd0));
    tbl.push_back(mv(0, 2'b01, 2'b00, 0, 32'h48,      32'h0,       5'd0, 3'd3, 1, 32'h40,      0, 5'd0, 0, 0, 0, 16'd0));
    tbl.push_back(mv(0, 2'b11, 2'b00, 0, 32'h4c,      32'h50,      5'd0, 3'd3, 1, 32'h40,      0, 5'd0, 1, 0, 0, 16'd2));
    tbl.push_back(mv(1, 2'b00, 2'b00, 0, 32'h0,       32'h0,       5'd0, 3'd0, 0, 32'h0,       0, 5'd0, 0, 0, 1, 16'd0));
    tbl.push_back(mv(0, 2'b10, 2'b00, 0, 32'h5c,      32'h60,      5'd0, 3'd1, 1, 32'h60,      0, 5'd0, 0, 0, 0, 16'd0));
    tbl.push_back(mv(0, 2'b00, 2'b00, 1, 32'h0,       32'h0,       5'd0, 3'd0, 0, 32'h0,       0, 5'd0, 0, 0, 1, 16'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].exc, 2'b00, 2'b00, tbl[i].rdy,
            tbl[i].pc0, tbl[i].pc1, tbl[i].cause);
      step();
      chk($sformatf("row%0d_occ", i), occupancy_o, tbl[i].occ);
      chk($sformatf("row%0d_valid", i), entry_valid_o, tbl[i].ev);
      chk($sformatf("row%0d_entry_valid_bit", i), entry_o.valid, tbl[i].ev);
      chk($sformatf("row%0d_pc", i), entry_o.pc, tbl[i].hpc);
      chk($sformatf("row%0d_exc", i), entry_o.exception, tbl[i].hexc);
      chk($sformatf("row%0d_cause", i), entry_o.cause, tbl[i].hcause);
      chk($sformatf("row%0d_ovf", i), overflow_o, tbl[i].ovf);
      chk($sformatf("row%0d_resync", i), resync_o, tbl[i].rsy);
      chk($sformatf("row%0d_idle", i), idle_o, tbl[i].idle);
`ifdef MURE_DROP_CNT_EN
      chk($sformatf("row%0d_dcnt", i), dropped_cnt, tbl[i].dcnt);
`endif
    end

    // Full buffer: a same-cycle pop does not make room for the capture.
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 32'h400 + 32'(k*4), 32'h0, 5'd0);
      step();
    end
    chk("full_occ", occupancy_o, DEPTH);
    drive(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 32'h4f0, 32'h0, 5'd0);
    step();
    chk("full_pop_occ", occupancy_o, DEPTH - 1);
    chk("full_pop_ovf", overflow_o, 1'b1);
    chk("full_pop_head", entry_o.pc, 32'h404);
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 32'h0, 32'h0, 5'd0);
    waited = 0;
    while (occupancy_o != 0 && waited < 20) begin
      step();
      waited++;
    end
    chk("drain_done", occupancy_o, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("wait_resync%0d_idle", k), idle_o, 1'b0);
      chk($sformatf("wait_resync%0d_ovf", k), overflow_o, 1'b1);
      chk($sformatf("wait_resync%0d_rsy", k), resync_o, 1'b0);
    end
    drive(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 32'h500, 32'h504, 5'd0);
    step();
    chk("resync_pair_rsy", resync_o, 1'b1);
    chk("resync_pair_occ", occupancy_o, 2);
    chk("resync_pair_head", entry_o.pc, 32'h500);
    chk("resync_pair_ovf", overflow_o, 1'b0);
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    chk("resync_pulse_end", resync_o, 1'b0);
    chk("resync_hold_head", entry_o.pc, 32'h500);

    // Random stimulus against the reference model.
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
    model_step();
    step();
    check_model(-1);
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] exc, intr;
      int rdy_pct;
      rdy_pct = (c < 1500) ? 35 : 80;
      exc  = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      intr = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
      drive(($urandom_range(0, 399) == 0), 2'($urandom_range(0, 3)), exc, intr,
            2'($urandom_range(0, 3)), ($urandom_range(0, 99) < rdy_pct),
            $urandom, $urandom, 5'($urandom_range(0, 31)));
      model_step();
      step();
      check_model(c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
